// File: rtl/des_perm_pipe.sv
// des_perm_pipe
//
// Purpose:
//   Pipelined DES bit-permutation block. Each accepted 64-bit block goes
//   through one of four operations, chosen per block by in_mode:
//     00 : swap halves {L16,R16} -> {R16,L16}, then final permutation FP
//     01 : initial permutation IP, result {L0,R0}
//     10 : final permutation FP, no swap
//     11 : pass-through
//   The permutation is computed combinationally at the input. The result
//   then moves through DEPTH register stages under valid/ready flow control.
//   DES bit 1 is the MSB of every 64-bit bus.
//
// Parameters:
//   DEPTH  number of register stages (1..4); this is the latency in cycles
//   CNT_W  width of the optional delivered-result counter
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    input block present
//   in_ready    block accepted this cycle (in_valid & in_ready = handshake)
//   in_mode     operation select, captured with in_data on handshake
//   in_data     64-bit input block
//   out_valid   result present
//   out_ready   downstream accepts result
//   out_data    64-bit permuted block
//   stat_count  delivered-result counter, present only when the macro
//               DES_PERM_STATS_EN is defined
//
// Configuration macro:
//   DES_PERM_STATS_EN  adds the stat_count port and its counter
module des_perm_pipe #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data
`ifdef DES_PERM_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_count
`endif
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $fatal(1, "des_perm_pipe: DEPTH=%0d is outside the legal range 1..4", DEPTH);
  end

  // FIPS 46-3 tables: output bit i (1-based, MSB first) takes input bit TAB[i].
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  // DES bit n lives at vector index 64-n, hence the index arithmetic below.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      src = 6'(64 - IP_TAB[6'(i)]);
      y[6'(63 - i)] = x[src];
    end
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      src = 6'(64 - FP_TAB[6'(i)]);
      y[6'(63 - i)] = x[src];
    end
    return y;
  endfunction

  logic [63:0] perm_data;

  logic        valid_q [DEPTH];
  logic        valid_d [DEPTH];
  logic [63:0] data_q  [DEPTH];
  logic [63:0] data_d  [DEPTH];
  logic        adv     [DEPTH];

  // The mode is applied here, before stage 1, so each stage only has to
  // carry the already-permuted data. A later change of in_mode cannot
  // affect a block that has already been captured.
  always_comb begin
    perm_data = in_data;
    case (in_mode)
      2'b00:   perm_data = fp_perm({in_data[31:0], in_data[63:32]});
      2'b01:   perm_data = ip_perm(in_data);
      2'b10:   perm_data = fp_perm(in_data);
      default: perm_data = in_data;
    endcase
  end

  // A stage may advance when there is a bubble at or after it, or the sink
  // is taking the last stage's result. Scanning from the output end with a
  // running flag avoids a chain of array elements feeding each other.
  always_comb begin : adv_scan
    logic bubble;
    bubble = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      bubble = bubble || !valid_q[i];
      adv[i] = bubble;
    end
  end

  // Advancing stages load from their predecessor; stage 1 loads from the
  // input. Data is only loaded when a valid block arrives, so idle stages
  // do not toggle their data registers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
    end
    if (adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = perm_data;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
  end

  // Stage registers. Reset empties the pipeline and clears the data so that
  // out_data reads zero while reset is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

`ifdef DES_PERM_STATS_EN
  logic [CNT_W-1:0] stat_count_q;
  logic [CNT_W-1:0] stat_count_d;

  // Counts output handshakes; wraps naturally at the counter width.
  always_comb begin
    stat_count_d = stat_count_q;
    if (out_valid && out_ready) begin
      stat_count_d = stat_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count_q <= '0;
    end else begin
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb_des_perm_pipe
//
// Self-checking bench for des_perm_pipe. The reference model derives IP
// from its row/column structure and obtains FP as the inverse of IP, then
// applies the per-mode rules. Outputs are compared against a queue of
// expected blocks in handshake order.
module tb_des_perm_pipe;

  localparam int DEPTH = 2;
`ifdef DES_PERM_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
`ifdef DES_PERM_STATS_EN
  logic [CNT_W-1:0] stat_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  des_perm_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DES_PERM_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IP row r starts at 58,60,62,64 (rows 0-3) or 57,59,61,63 (rows 4-7)
  // and steps down by 8 per column. Returns the source DES bit number.
  function automatic int ip_src(input int pos);
    int r;
    int c;
    r = (pos - 1) / 8;
    c = (pos - 1) % 8;
    return ((r < 4) ? (58 + 2 * r) : (49 + 2 * r)) - 8 * c;
  endfunction

  function automatic logic [63:0] model_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int p = 1; p <= 64; p++) y[64 - p] = x[64 - ip_src(p)];
    return y;
  endfunction

  function automatic logic [63:0] model_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int p = 1; p <= 64; p++) y[64 - ip_src(p)] = x[64 - p];
    return y;
  endfunction

  function automatic logic [63:0] ref_model(input logic [1:0] m, input logic [63:0] d);
    case (m)
      2'b00:   return model_fp({d[31:0], d[63:32]});
      2'b01:   return model_ip(d);
      2'b10:   return model_fp(d);
      default: return d;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_data !== 64'h0) begin
      miscompares++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
`ifdef DES_PERM_STATS_EN
    vectors++;
    if (stat_count !== '0) begin
      miscompares++; $display("[TB] FAIL reset_stat: got %0d expected 0", stat_count);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_known_vectors();
    logic [1:0]  k_mode [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [63:0] k_in   [4] = '{64'h0123456789ABCDEF, 64'h434232340A4CD995,
                                64'hCC00CCFFF0AAF0AA, 64'hDEADBEEFCAFEF00D};
    logic [63:0] k_exp  [4] = '{64'hCC00CCFFF0AAF0AA, 64'h85E813540F0AB405,
                                64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D};
    int cycles;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_mode = k_mode[k]; in_data = k_in[k];
      cycles = 0;
      do begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles++;
      end while (!out_valid && cycles < 20);
      vectors++;
      if (cycles !== DEPTH) begin
        miscompares++; $display("[TB] FAIL known_latency[%0d]: got %0d cycles expected %0d", k, cycles, DEPTH);
      end
      vectors++;
      if (out_data !== k_exp[k]) begin
        miscompares++; $display("[TB] FAIL known_data[%0d]: got %h expected %h", k, out_data, k_exp[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_trip();
    localparam int N = 1000;
    logic [63:0] orig [N];
    logic [63:0] mid  [N];
    logic [63:0] exp;
    int in_idx, out_idx, cyc, stall;
    for (int i = 0; i < N; i++) orig[i] = {$urandom(), $urandom()};
    for (int pass = 0; pass < 2; pass++) begin
      in_idx = 0; out_idx = 0; cyc = 0; stall = 0;
      out_ready = 1'b1;
      while (out_idx < N && cyc < N + 100) begin
        if (in_idx < N) begin
          in_valid = 1'b1;
          in_mode  = (pass == 0) ? 2'b01 : 2'b10;
          in_data  = (pass == 0) ? orig[in_idx] : mid[in_idx];
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        if (in_valid && !in_ready) stall++;
        if (out_valid && out_ready) begin
          exp = (pass == 0) ? model_ip(orig[out_idx]) : orig[out_idx];
          vectors++;
          if (out_data !== exp) begin
            miscompares++;
            $display("[TB] FAIL round_trip p%0d[%0d]: got %h expected %h", pass, out_idx, out_data, exp);
          end
          if (pass == 0) mid[out_idx] = out_data;
          out_idx++;
        end
        if (in_valid && in_ready) in_idx++;
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      vectors++;
      if (out_idx !== N) begin
        miscompares++; $display("[TB] FAIL round_trip_count p%0d: got %0d expected %0d", pass, out_idx, N);
      end
      vectors++;
      if (stall !== 0 || cyc !== N + DEPTH) begin
        miscompares++;
        $display("[TB] FAIL throughput p%0d: got %0d stalls %0d cycles expected 0 stalls %0d cycles",
                 pass, stall, cyc, N + DEPTH);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_q [$];
    logic [63:0] exp;
    int accepted = 0, sent, got = 0, guard = 0, target;
    bit need_new = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (need_new) begin
        in_mode = 2'($urandom_range(0, 3)); in_data = {$urandom(), $urandom()}; need_new = 1'b0;
      end
      in_valid = 1'b1;
      @(negedge clk);
      if (c >= DEPTH) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++; $display("[TB] FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
          miscompares++;
          $display("[TB] FAIL bp_hold c%0d: got valid=%b data=%h expected 1/%h", c, out_valid, out_data, exp_q[0]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_mode, in_data)); accepted++; need_new = 1'b1;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (accepted !== DEPTH) begin
      miscompares++; $display("[TB] FAIL bp_occupancy: got %0d expected %0d", accepted, DEPTH);
    end
    target = DEPTH + 5;
    sent = accepted;
    out_ready = 1'b1;
    while (got < target && guard < 100) begin
      if (sent < target) begin
        if (need_new) begin
          in_mode = 2'($urandom_range(0, 3)); in_data = {$urandom(), $urandom()}; need_new = 1'b0;
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (guard == 0) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++; $display("[TB] FAIL bp_no_bubble: got in_ready=%b expected 1", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL bp_dup: got extra block %h expected none", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            miscompares++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", got, out_data, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_mode, in_data)); sent++; need_new = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    vectors++;
    if (got !== target) begin
      miscompares++; $display("[TB] FAIL bp_count: got %0d expected %0d", got, target);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_drained: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random_stream();
    localparam int N = 300;
    logic [63:0] exp_q [$];
    logic [63:0] exp;
    int sent = 0, got = 0, guard = 0;
    bit need_new = 1'b1;
    in_valid = 1'b0;
    while (got < N && guard < 5000) begin
      if (sent < N) begin
        if (need_new && $urandom_range(0, 3) != 0) begin
          in_mode = 2'($urandom_range(0, 3)); in_data = {$urandom(), $urandom()};
          in_valid = 1'b1; need_new = 1'b0;
        end else if (need_new) begin
          in_valid = 1'b0; in_mode = 2'($urandom_range(0, 3));
        end
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL rand_dup: got extra block %h expected none", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            miscompares++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", got, out_data, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_mode, in_data)); sent++; need_new = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got !== N) begin
      miscompares++; $display("[TB] FAIL rand_count: got %0d expected %0d", got, N);
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] blk;
    int filled = 0, guard = 0, cycles;
    out_ready = 1'b0;
    while (filled < DEPTH && guard < 20) begin
      in_valid = 1'b1; in_mode = 2'($urandom_range(0, 3)); in_data = {$urandom(), $urandom()};
      @(negedge clk);
      if (in_ready) filled++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_prefull: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_async: got valid=%b data=%h in_ready=%b expected 0/0/1", out_valid, out_data, in_ready);
    end
`ifdef DES_PERM_STATS_EN
    vectors++;
    if (stat_count !== '0) begin
      miscompares++; $display("[TB] FAIL rst_stat: got %0d expected 0", stat_count);
    end
`endif
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    blk = {$urandom(), $urandom()};
    in_valid = 1'b1; in_mode = 2'b01; in_data = blk; out_ready = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      cycles++;
    end while (!out_valid && cycles < 20);
    vectors++;
    if (cycles !== DEPTH || out_data !== model_ip(blk)) begin
      miscompares++;
      $display("[TB] FAIL rst_next_block: got %h after %0d cycles expected %h after %0d",
               out_data, cycles, model_ip(blk), DEPTH);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_stale: got out_valid=%b expected 0", out_valid);
    end
  endtask

`ifdef DES_PERM_STATS_EN
  task automatic test_counter();
    int sent = 0, got = 0, guard = 0;
    logic [CNT_W-1:0] exp_cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (got < 17 && guard < 100) begin
      in_valid = (sent < 17); in_mode = 2'($urandom_range(0, 3)); in_data = {$urandom(), $urandom()};
      @(negedge clk);
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    exp_cnt = CNT_W'(17);
    vectors++;
    if (got !== 17 || stat_count !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL stat_wrap: got %0d after %0d deliveries expected %0d after 17", stat_count, got, exp_cnt);
    end
  endtask
`endif

  // Scenario sequence; each task leaves the bench just after a rising edge.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; out_ready = 1'b0;
    $display("[TB] des_perm_pipe bench, DEPTH=%0d", DEPTH);
    test_reset();
    test_known_vectors();
    test_round_trip();
    test_backpressure();
    test_random_stream();
    test_reset_midflight();
`ifdef DES_PERM_STATS_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
